sos_receive_module: RTL and testbench
=====================================

Name: sos_receive_module

Overview:
Morse receiver, the decode side of the S-O-S transmit sequencer. Samples a debounced key, times each press and release in Morse units, and classifies presses as dot or dash. Groups symbols into letters (S, O, other) and pulses done_sig when a complete S-O-S is keyed within one word. Sits beside the transmit sequencer under the same start_sig/done_sig control scheme.

Parameters:
UNIT_CYCLES, 2500000, clk cycles per Morse time unit (50 ms at 50 MHz); must be >= 2.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start_sig  input  1  level enable; low holds block idle and cleared
key_in  input  1  debounced key, active-low (0 = pressed)
sym_valid  output  1  one-cycle pulse, symbol classified
sym_is_dash  output  1  qualifies sym_valid: 1 = dash, 0 = dot
letter_valid  output  1  one-cycle pulse, letter ended
letter_code  output  2  qualifies letter_valid: 01 = S, 10 = O, 00 = other/bad, 11 unused
done_sig  output  1  one-cycle pulse, S-O-S recognised

Behaviour:
- Reset (async) and start_sig=0 (sync) force state IDLE. Both clear all counters, the symbol buffer and the letter history, and drive every output to 0.
- key = ~key_in, registered into k_q; previous value held in k_d. rise = k_q & ~k_d; fall = ~k_q & k_d.
- Timebase: cyc counts 0..UNIT_CYCLES-1 and wraps to 0. On wrap, units <= min(units+1, 15). cyc and units are zeroed on every rise/fall.
- FSM states: IDLE, MARK, SPACE.
  - IDLE: on rise -> MARK. A key already held when start_sig rises is ignored until it is released and pressed again.
  - MARK, on fall: classify by units. 0-1 -> dot. 2-5 -> dash. >=6 -> bad flag set, and the symbol is reported as dash. Append the symbol to a 4-entry buffer (sym_cnt saturates at 4). A 5th symbol sets bad. Next state SPACE.
  - SPACE: rise while units<3 -> MARK (intra-letter gap).
  - SPACE: units reaching 3 -> end of letter. S = sym_cnt 3, all dots, not bad. O = sym_cnt 3, all dashes, not bad. Anything else -> 00. Then clear the buffer, sym_cnt and bad, and stay in SPACE.
  - SPACE: rise at units 3-6 -> MARK, starting a new letter of the same word.
  - SPACE: units reaching 7 -> word end. Clear the letter history; -> IDLE.
- Output timing:
  - sym_valid/sym_is_dash register one cycle after the fall is detected.
  - letter_valid/letter_code register one cycle after units becomes 3.
- Letter history: 2 entries (prev2, prev1), shifted on every letter_valid.
  - done_sig pulses in the same cycle as letter_valid when the new letter is S, prev2 = S and prev1 = O.
  - On done, the history is cleared, so no overlapping matches: SOSOS yields one done.
- Pulse outputs are never high for more than 1 cycle; outputs hold 0 otherwise.
- A fall and a cyc wrap in the same cycle: the fall wins, and units for classification is the pre-increment value.

Optional Feature:
- SOS_RX_SYNC_EN defined: key_in passes through a 2-flop synchronizer before k_q, adding 2 cycles to all key-relative latencies.
- Undefined: key_in must be synchronous to clk and is registered once.

Test Plan:
All scenarios use UNIT_CYCLES=4 and start_sig=1 unless noted.
1. Key S: three 4-cycle presses, 4-cycle gaps, then 40 cycles released -> 3x sym_valid with sym_is_dash=0; one letter_valid with letter_code=01; done_sig=0; FSM returns to IDLE.
2. Key O: three 12-cycle presses, 4-cycle gaps -> 3x sym_is_dash=1, then letter_code=10.
3. S, O, S with 12-cycle letter gaps, then 40 idle -> 3 letter_valid pulses (01, 10, 01); done_sig high exactly once, in the same cycle as the third letter_valid.
4. S, then a 28-cycle gap, then O, then S -> no done_sig, because the word-end cleared the history. Separately, a 30-cycle press inside an S -> letter_code=00 and no done.
5. Mid-letter interruptions:
   - start_sig dropped for 1 cycle after two dots -> all outputs 0, no letter_valid; the next full SOS still gives done.
   - rst_n asserted mid-press -> all outputs 0 immediately.
6. SOSOS keyed contiguously -> exactly one done_sig. Rebuild with SOS_RX_SYNC_EN -> every output pulse shifts later by exactly 2 cycles.

Source files
------------

// File: rtl/sos_receive_module_if.sv
// rtl/sos_receive_module_if.sv - Key/enable inputs and decode event outputs of the S-O-S receiver
interface sos_receive_module_if;
    logic       start_sig;
    logic       key_in;
    logic       sym_valid;
    logic       sym_is_dash;
    logic       letter_valid;
    logic [1:0] letter_code;
    logic       done_sig;

    modport master (
        output start_sig, key_in,
        input  sym_valid, sym_is_dash, letter_valid, letter_code, done_sig
    );

    modport slave (
        input  start_sig, key_in,
        output sym_valid, sym_is_dash, letter_valid, letter_code, done_sig
    );
endinterface

// File: rtl/sos_receive_module.sv
// rtl/sos_receive_module.sv - Morse key decoder pulsing done_sig on S-O-S within one word
// Optional: define SOS_RX_SYNC_EN to pass key_in through a 2-flop synchronizer.
module sos_receive_module #(
    parameter int UNIT_CYCLES = 2500000
) (
    input  logic                clk,
    input  logic                rst_n,
    sos_receive_module_if.slave bus
);
    localparam int              CW       = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0]   CYC_LAST = CW'(UNIT_CYCLES - 1);
    localparam logic [1:0]      CODE_X   = 2'b00;
    localparam logic [1:0]      CODE_S   = 2'b01;
    localparam logic [1:0]      CODE_O   = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, SPACE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            key_q, key_d, key_prev_q, key_prev_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [3:0]      units_q, units_d;
    logic [3:0]      sym_buf_q, sym_buf_d;
    logic [2:0]      sym_cnt_q, sym_cnt_d;
    logic            bad_q, bad_d;
    logic [1:0]      prev1_q, prev1_d, prev2_q, prev2_d;
    logic            sym_valid_q, sym_valid_d;
    logic            sym_is_dash_q, sym_is_dash_d;
    logic            letter_valid_q, letter_valid_d;
    logic [1:0]      letter_code_q, letter_code_d;
    logic            done_q, done_d;
    logic            key_now, rise, fall, unit_start, is_dash;
    logic [1:0]      code_now;

`ifdef SOS_RX_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], ~bus.key_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign key_now = sync_q[1];
`else
    assign key_now = ~bus.key_in;
`endif

    assign rise       = key_q & ~key_prev_q;
    assign fall       = ~key_q & key_prev_q;
    assign unit_start = (cyc_q == '0);
    assign is_dash    = (units_q >= 4'd2);

    always_comb begin
        code_now = CODE_X;
        if (sym_cnt_q == 3'd3 && !bad_q && sym_buf_q[2:0] == 3'b000)      code_now = CODE_S;
        else if (sym_cnt_q == 3'd3 && !bad_q && sym_buf_q[2:0] == 3'b111) code_now = CODE_O;
    end

    always_comb begin
        key_d          = key_now;
        key_prev_d     = key_q;
        state_d        = state_q;
        cyc_d          = cyc_q;
        units_d        = units_q;
        sym_buf_d      = sym_buf_q;
        sym_cnt_d      = sym_cnt_q;
        bad_d          = bad_q;
        prev1_d        = prev1_q;
        prev2_d        = prev2_q;
        sym_valid_d    = 1'b0;
        sym_is_dash_d  = 1'b0;
        letter_valid_d = 1'b0;
        letter_code_d  = CODE_X;
        done_d         = 1'b0;

        // The edge-detect cycle is itself the first cycle of the new interval.
        if (rise || fall) begin
            cyc_d   = CW'(1);
            units_d = 4'd0;
        end else if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (units_q != 4'd15) units_d = units_q + 4'd1;
        end else begin
            cyc_d = cyc_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (rise) state_d = MARK;
            end
            MARK: begin
                if (fall) begin
                    sym_valid_d   = 1'b1;
                    sym_is_dash_d = is_dash;
                    if (units_q >= 4'd6) bad_d = 1'b1;
                    if (sym_cnt_q == 3'd4) begin
                        bad_d = 1'b1;
                    end else begin
                        sym_buf_d[sym_cnt_q[1:0]] = is_dash;
                        sym_cnt_d                 = sym_cnt_q + 3'd1;
                    end
                    state_d = SPACE;
                end
            end
            SPACE: begin
                if (unit_start && units_q == 4'd3) begin
                    letter_valid_d = 1'b1;
                    letter_code_d  = code_now;
                    sym_buf_d      = '0;
                    sym_cnt_d      = '0;
                    bad_d          = 1'b0;
                    if (code_now == CODE_S && prev2_q == CODE_S && prev1_q == CODE_O) begin
                        done_d  = 1'b1;
                        prev1_d = CODE_X;
                        prev2_d = CODE_X;
                    end else begin
                        prev2_d = prev1_q;
                        prev1_d = code_now;
                    end
                end
                if (rise) begin
                    state_d = MARK;
                end else if (unit_start && units_q == 4'd7) begin
                    state_d = IDLE;
                end
                if (unit_start && units_q == 4'd7) begin
                    prev1_d = CODE_X;
                    prev2_d = CODE_X;
                end
            end
            default: state_d = IDLE;
        endcase

        // Key sampling keeps running so a key held across enable is not seen as a new press.
        if (!bus.start_sig) begin
            state_d        = IDLE;
            cyc_d          = '0;
            units_d        = 4'd0;
            sym_buf_d      = '0;
            sym_cnt_d      = '0;
            bad_d          = 1'b0;
            prev1_d        = CODE_X;
            prev2_d        = CODE_X;
            sym_valid_d    = 1'b0;
            sym_is_dash_d  = 1'b0;
            letter_valid_d = 1'b0;
            letter_code_d  = CODE_X;
            done_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            key_q          <= 1'b0;
            key_prev_q     <= 1'b0;
            cyc_q          <= '0;
            units_q        <= 4'd0;
            sym_buf_q      <= '0;
            sym_cnt_q      <= '0;
            bad_q          <= 1'b0;
            prev1_q        <= CODE_X;
            prev2_q        <= CODE_X;
            sym_valid_q    <= 1'b0;
            sym_is_dash_q  <= 1'b0;
            letter_valid_q <= 1'b0;
            letter_code_q  <= CODE_X;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            key_prev_q     <= key_prev_d;
            cyc_q          <= cyc_d;
            units_q        <= units_d;
            sym_buf_q      <= sym_buf_d;
            sym_cnt_q      <= sym_cnt_d;
            bad_q          <= bad_d;
            prev1_q        <= prev1_d;
            prev2_q        <= prev2_d;
            sym_valid_q    <= sym_valid_d;
            sym_is_dash_q  <= sym_is_dash_d;
            letter_valid_q <= letter_valid_d;
            letter_code_q  <= letter_code_d;
            done_q         <= done_d;
        end
    end

    assign bus.sym_valid    = sym_valid_q;
    assign bus.sym_is_dash  = sym_is_dash_q;
    assign bus.letter_valid = letter_valid_q;
    assign bus.letter_code  = letter_code_q;
    assign bus.done_sig     = done_q;
endmodule

// File: tb/tb_sos_receive_module.sv
// tb/tb_sos_receive_module.sv - Self-checking bench for sos_receive_module against a timing/letter model
module tb_sos_receive_module;
    localparam int U = 4;
`ifdef SOS_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    sos_receive_module_if bus();

    sos_receive_module #(.UNIT_CYCLES(U)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Events packed as {kind, data, edge}; kind 1 = symbol, 2 = letter, 3 = done.
    logic [31:0] exp_ev[$];
    logic [31:0] got_ev[$];

    function automatic logic [31:0] ev(input int kind, input int data, input int t);
        return {kind[1:0], data[1:0], t[27:0]};
    endfunction

    always @(negedge clk) begin
        if (bus.sym_valid)    got_ev.push_back(ev(1, int'(bus.sym_is_dash), edge_n));
        if (bus.letter_valid) got_ev.push_back(ev(2, int'(bus.letter_code), edge_n));
        if (bus.done_sig)     got_ev.push_back(ev(3, 0, edge_n));
    end

    int cur_syms = 0;
    int cur_dash = 0;
    bit cur_bad = 1'b0;
    int hist[$];
    int last_fall = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        cur_syms = 0;
        cur_dash = 0;
        cur_bad  = 1'b0;
        hist.delete();
    endtask

    task automatic do_press(input int d);
        bus.key_in = 1'b0;
        tick(d);
        bus.key_in = 1'b1;
        last_fall = edge_n + 1;
        exp_ev.push_back(ev(1, (d / U >= 2) ? 1 : 0, last_fall + 1 + LAT));
        cur_syms++;
        if (d / U >= 2) cur_dash++;
        if (d / U >= 6) cur_bad = 1'b1;
    endtask

    task automatic do_gap(input int g);
        int code;
        tick(g);
        if (g / U >= 3 && cur_syms > 0) begin
            code = 0;
            if (cur_syms == 3 && !cur_bad && cur_dash == 0) code = 1;
            if (cur_syms == 3 && !cur_bad && cur_dash == 3) code = 2;
            exp_ev.push_back(ev(2, code, last_fall + 3 * U + 1 + LAT));
            if (code == 1 && hist.size() >= 2 && hist[hist.size() - 1] == 2 && hist[hist.size() - 2] == 1) begin
                exp_ev.push_back(ev(3, 0, last_fall + 3 * U + 1 + LAT));
                hist.delete();
            end else begin
                hist.push_back(code);
            end
            cur_syms = 0;
            cur_dash = 0;
            cur_bad  = 1'b0;
        end
        if (g / U >= 7) hist.delete();
    endtask

    task automatic send_s(input int g);
        do_press(U); do_gap(U); do_press(U); do_gap(U); do_press(U); do_gap(g);
    endtask

    task automatic send_o(input int g);
        do_press(3 * U); do_gap(U); do_press(3 * U); do_gap(U); do_press(3 * U); do_gap(g);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL reset sym_valid: got %b expected 0", bus.sym_valid); end
        checks++; if (bus.sym_is_dash !== 1'b0) begin errors++; $display("FAIL reset sym_is_dash: got %b expected 0", bus.sym_is_dash); end
        checks++; if (bus.letter_valid !== 1'b0) begin errors++; $display("FAIL reset letter_valid: got %b expected 0", bus.letter_valid); end
        checks++; if (bus.letter_code !== 2'b00) begin errors++; $display("FAIL reset letter_code: got %b expected 00", bus.letter_code); end
        checks++; if (bus.done_sig !== 1'b0) begin errors++; $display("FAIL reset done_sig: got %b expected 0", bus.done_sig); end
        rst_n = 1'b1;
        tick(4);
        got_ev.delete();
        exp_ev.delete();
    endtask

    task automatic test_letter_s();
        got_ev.delete(); exp_ev.delete(); model_clear();
        send_s(40);
        checks++;
        if (got_ev.size() !== exp_ev.size()) begin errors++; $display("FAIL letter_s count: got %0d expected %0d", got_ev.size(), exp_ev.size()); end
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
            checks++;
            if (got_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL letter_s event %0d: got %h expected %h", i, got_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_letter_o();
        got_ev.delete(); exp_ev.delete(); model_clear();
        send_o(40);
        checks++;
        if (got_ev.size() !== exp_ev.size()) begin errors++; $display("FAIL letter_o count: got %0d expected %0d", got_ev.size(), exp_ev.size()); end
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
            checks++;
            if (got_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL letter_o event %0d: got %h expected %h", i, got_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_sos();
        got_ev.delete(); exp_ev.delete(); model_clear();
        send_s(3 * U); send_o(3 * U); send_s(40);
        checks++;
        if (got_ev.size() !== exp_ev.size()) begin errors++; $display("FAIL sos count: got %0d expected %0d", got_ev.size(), exp_ev.size()); end
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
            checks++;
            if (got_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL sos event %0d: got %h expected %h", i, got_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_word_gap_and_long_press();
        got_ev.delete(); exp_ev.delete(); model_clear();
        send_s(7 * U); send_o(3 * U); send_s(40);
        do_press(U); do_gap(U); do_press(30); do_gap(U); do_press(U); do_gap(40);
        checks++;
        if (got_ev.size() !== exp_ev.size()) begin errors++; $display("FAIL word_gap count: got %0d expected %0d", got_ev.size(), exp_ev.size()); end
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
            checks++;
            if (got_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL word_gap event %0d: got %h expected %h", i, got_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_start_drop();
        got_ev.delete(); exp_ev.delete(); model_clear();
        do_press(U); do_gap(U); do_press(U);
        tick(6);
        bus.start_sig = 1'b0;
        tick(1);
        bus.start_sig = 1'b1;
        model_clear();
        tick(40);
        send_s(3 * U); send_o(3 * U); send_s(40);
        checks++;
        if (got_ev.size() !== exp_ev.size()) begin errors++; $display("FAIL start_drop count: got %0d expected %0d", got_ev.size(), exp_ev.size()); end
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
            checks++;
            if (got_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL start_drop event %0d: got %h expected %h", i, got_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_reset_mid_press();
        got_ev.delete(); exp_ev.delete(); model_clear();
        do_press(U);
        while (edge_n < last_fall + 1 + LAT) tick(1);
        bus.key_in = 1'b0;
        checks++; if (bus.sym_valid !== 1'b1) begin errors++; $display("FAIL pre_reset sym_valid: got %b expected 1", bus.sym_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL midreset sym_valid: got %b expected 0", bus.sym_valid); end
        checks++; if (bus.letter_valid !== 1'b0) begin errors++; $display("FAIL midreset letter_valid: got %b expected 0", bus.letter_valid); end
        checks++; if (bus.letter_code !== 2'b00) begin errors++; $display("FAIL midreset letter_code: got %b expected 00", bus.letter_code); end
        checks++; if (bus.done_sig !== 1'b0) begin errors++; $display("FAIL midreset done_sig: got %b expected 0", bus.done_sig); end
        bus.key_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        got_ev.delete(); exp_ev.delete(); model_clear();
        tick(40);
        checks++;
        if (got_ev.size() !== 0) begin errors++; $display("FAIL midreset events: got %0d expected 0", got_ev.size()); end
    endtask

    task automatic test_sosos();
        got_ev.delete(); exp_ev.delete(); model_clear();
        send_s(3 * U); send_o(3 * U); send_s(3 * U); send_o(3 * U); send_s(40);
        checks++;
        if (got_ev.size() !== exp_ev.size()) begin errors++; $display("FAIL sosos count: got %0d expected %0d", got_ev.size(), exp_ev.size()); end
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
            checks++;
            if (got_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL sosos event %0d: got %h expected %h", i, got_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_random();
        int n_letters, kind, n_syms, t, d, g;
        got_ev.delete(); exp_ev.delete(); model_clear();
        for (int w = 0; w < 6; w++) begin
            n_letters = $urandom_range(1, 3);
            for (int l = 0; l < n_letters; l++) begin
                kind   = $urandom_range(0, 4);
                n_syms = (kind >= 4) ? $urandom_range(1, 5) : 3;
                for (int s = 0; s < n_syms; s++) begin
                    t = (kind <= 1) ? 0 : (kind <= 3) ? 3 : $urandom_range(0, 5);
                    if (t <= 2)      d = $urandom_range(2, 2 * U - 1);
                    else if (t <= 4) d = $urandom_range(2 * U, 6 * U - 1);
                    else             d = $urandom_range(6 * U, 8 * U);
                    if (s < n_syms - 1)         g = $urandom_range(2, 3 * U - 1);
                    else if (l < n_letters - 1) g = $urandom_range(3 * U, 7 * U - 1);
                    else                        g = $urandom_range(7 * U, 9 * U);
                    do_press(d);
                    do_gap(g);
                end
            end
        end
        tick(40);
        checks++;
        if (got_ev.size() !== exp_ev.size()) begin errors++; $display("FAIL random count: got %0d expected %0d", got_ev.size(), exp_ev.size()); end
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
            checks++;
            if (got_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL random event %0d: got %h expected %h", i, got_ev[i], exp_ev[i]); end
        end
    endtask

    initial begin
        bus.start_sig = 1'b1;
        bus.key_in    = 1'b1;
        test_reset();
        test_letter_s();
        test_letter_o();
        test_sos();
        test_word_gap_and_long_press();
        test_start_drop();
        test_reset_mid_press();
        test_sosos();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
